// File: rtl/calc_key_sequencer.sv
// ----------------------------------------------------------------------------
// calc_key_sequencer
//
// Sits between the keypad scanner and the ALU/display path. Consumes 5-bit key
// codes, builds signed hex operands from digit keys, tracks the pending
// operator and issues one request per operation to the ALU. A successful ALU
// result becomes operand A of the next operation, so chains like 5*3-2= work
// without re-entering intermediate values.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   i_key_data        key code: 0dddd digit, 100oo operator, 10100 eq,
//                     10101 AC, 10110 neg, anything else reserved
//   i_key_valid       key code valid
//   o_key_ready       key can be consumed this cycle
//   o_alu_a/b/op      request operands (two's complement) and opcode
//   o_alu_valid       request valid, held until i_alu_ready
//   i_alu_ready       ALU accepts the request
//   i_alu_done        single-cycle result strobe
//   i_alu_result      result, valid with i_alu_done
//   i_alu_error       error flag, valid with i_alu_done
//   o_display         signed value to show
//   o_display_error   error indicator
// ----------------------------------------------------------------------------
module calc_key_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       i_key_data,
    input  logic             i_key_valid,
    output logic             o_key_ready,
    output logic [WIDTH-1:0] o_alu_a,
    output logic [WIDTH-1:0] o_alu_b,
    output logic [1:0]       o_alu_op,
    output logic             o_alu_valid,
    input  logic             i_alu_ready,
    input  logic             i_alu_done,
    input  logic [WIDTH-1:0] i_alu_result,
    input  logic             i_alu_error,
    output logic [WIDTH-1:0] o_display,
    output logic             o_display_error
);

    typedef enum logic [2:0] {
        S_ENTER_A,
        S_OP_PENDING,
        S_ENTER_B,
        S_ISSUE,
        S_WAIT,
        S_RESULT,
        S_ERROR
    } state_t;

    localparam logic [4:0] KEY_EQ  = 5'b10100;
    localparam logic [4:0] KEY_AC  = 5'b10101;
    localparam logic [4:0] KEY_NEG = 5'b10110;

    state_t           state_q, state_d;

    // Single entry register shared by the A and B operands; it is reloaded
    // whenever entry switches from one operand to the other.
    logic [WIDTH-1:0] mag_q, mag_d;
    logic             sign_q, sign_d;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       op_q, op_d;

    // Operator typed to terminate B; it becomes the next op once the
    // current result is back.
    logic             pend_vld_q, pend_vld_d;
    logic [1:0]       pend_op_q, pend_op_d;

    logic             key_fire;
    logic             is_digit, is_op, is_eq, is_ac, is_neg;
    logic             digit_fits;
    logic [WIDTH-1:0] entry_val;
    logic [WIDTH-1:0] mag_shift;
    logic [WIDTH-1:0] mag_digit;

    // ------------------------------------------------------------------------
    // Key decode
    // ------------------------------------------------------------------------
    assign o_key_ready = (state_q != S_ISSUE) && (state_q != S_WAIT);
    assign key_fire    = i_key_valid && o_key_ready;

    assign is_digit = ~i_key_data[4];
    assign is_op    = (i_key_data[4:2] == 3'b100);
    assign is_eq    = (i_key_data == KEY_EQ);
    assign is_ac    = (i_key_data == KEY_AC);
    assign is_neg   = (i_key_data == KEY_NEG);

    // Another hex digit only fits while the top five bits are clear; this
    // keeps the magnitude at or below the largest positive value.
    assign digit_fits = (mag_q[WIDTH-1:WIDTH-5] == '0);
    assign mag_shift  = {mag_q[WIDTH-5:0], i_key_data[3:0]};
    assign mag_digit  = {{(WIDTH-4){1'b0}}, i_key_data[3:0]};

    // Negating a zero magnitude yields zero, so -0 never reaches the display.
    assign entry_val  = sign_q ? (-mag_q) : mag_q;

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign o_alu_valid     = (state_q == S_ISSUE);
    assign o_alu_a         = a_q;
    assign o_alu_b         = b_q;
    assign o_alu_op        = op_q;
    assign o_display_error = (state_q == S_ERROR);

    always_comb begin
        o_display = a_q;
        case (state_q)
            S_ENTER_A, S_ENTER_B: o_display = entry_val;
            S_ERROR:              o_display = '0;
            default:              o_display = a_q;
        endcase
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        mag_d      = mag_q;
        sign_d     = sign_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        pend_vld_d = pend_vld_q;
        pend_op_d  = pend_op_q;

        if (key_fire && is_ac) begin
            // AC wins in every state that can take a key, including ERROR.
            state_d    = S_ENTER_A;
            mag_d      = '0;
            sign_d     = 1'b0;
            a_d        = '0;
            b_d        = '0;
            op_d       = 2'b00;
            pend_vld_d = 1'b0;
            pend_op_d  = 2'b00;
        end else begin
            case (state_q)
                S_ENTER_A: begin
                    if (key_fire) begin
                        if (is_digit) begin
                            if (digit_fits) mag_d = mag_shift;
                        end else if (is_neg) begin
                            sign_d = ~sign_q;
                        end else if (is_op) begin
                            a_d     = entry_val;
                            op_d    = i_key_data[1:0];
                            state_d = S_OP_PENDING;
                        end
                    end
                end

                S_OP_PENDING: begin
                    if (key_fire) begin
                        if (is_digit) begin
                            mag_d   = mag_digit;
                            sign_d  = 1'b0;
                            state_d = S_ENTER_B;
                        end else if (is_neg) begin
                            mag_d   = '0;
                            sign_d  = 1'b1;
                            state_d = S_ENTER_B;
                        end else if (is_op) begin
                            op_d = i_key_data[1:0];
                        end
                    end
                end

                S_ENTER_B: begin
                    if (key_fire) begin
                        if (is_digit) begin
                            if (digit_fits) mag_d = mag_shift;
                        end else if (is_neg) begin
                            sign_d = ~sign_q;
                        end else if (is_op || is_eq) begin
                            b_d        = entry_val;
                            pend_vld_d = is_op;
                            pend_op_d  = is_op ? i_key_data[1:0] : 2'b00;
                            state_d    = S_ISSUE;
                        end
                    end
                end

                S_ISSUE: begin
                    if (i_alu_ready) state_d = S_WAIT;
                end

                S_WAIT: begin
                    if (i_alu_done) begin
                        if (i_alu_error) begin
                            state_d = S_ERROR;
                        end else begin
                            a_d = i_alu_result;
                            if (pend_vld_q) begin
                                op_d       = pend_op_q;
                                pend_vld_d = 1'b0;
                                state_d    = S_OP_PENDING;
                            end else begin
                                state_d = S_RESULT;
                            end
                        end
                    end
                end

                S_RESULT: begin
                    if (key_fire) begin
                        if (is_digit) begin
                            mag_d   = mag_digit;
                            sign_d  = 1'b0;
                            state_d = S_ENTER_A;
                        end else if (is_neg) begin
                            // Wraps: the most negative value maps to itself.
                            a_d = -a_q;
                        end else if (is_op) begin
                            op_d    = i_key_data[1:0];
                            state_d = S_OP_PENDING;
                        end
                    end
                end

                S_ERROR: begin
                    // Only AC (handled above) leaves this state.
                end

                default: state_d = S_ENTER_A;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_ENTER_A;
            mag_q      <= '0;
            sign_q     <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= 2'b00;
            pend_vld_q <= 1'b0;
            pend_op_q  <= 2'b00;
        end else begin
            state_q    <= state_d;
            mag_q      <= mag_d;
            sign_q     <= sign_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            pend_vld_q <= pend_vld_d;
            pend_op_q  <= pend_op_d;
        end
    end

endmodule

// File: tb/tb_calc_key_sequencer.sv
// ----------------------------------------------------------------------------
// tb_calc_key_sequencer
//
// Directed key sequences against calc_key_sequencer. A calculator model keeps
// operand values as plain signed integers and is compared with the DUT on
// every falling clock edge; literal expectations at key points pin the model.
// ----------------------------------------------------------------------------
module tb_calc_key_sequencer;

    localparam int W = 16;

    localparam logic [4:0] K_ADD = 5'h10;
    localparam logic [4:0] K_SUB = 5'h11;
    localparam logic [4:0] K_MUL = 5'h12;
    localparam logic [4:0] K_DIV = 5'h13;
    localparam logic [4:0] K_EQ  = 5'h14;
    localparam logic [4:0] K_AC  = 5'h15;
    localparam logic [4:0] K_NEG = 5'h16;

    // Calculator modes
    localparam int M_EA   = 0;   // typing A
    localparam int M_OP   = 1;   // operator chosen, nothing of B typed
    localparam int M_EB   = 2;   // typing B
    localparam int M_REQ  = 3;   // request offered to ALU
    localparam int M_BUSY = 4;   // ALU working
    localparam int M_RES  = 5;   // showing a result
    localparam int M_ERR  = 6;   // error shown

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    key_data;
    logic          key_valid;
    logic          key_ready;
    logic [W-1:0]  alu_a, alu_b;
    logic [1:0]    alu_op;
    logic          alu_valid;
    logic          alu_ready;
    logic          alu_done;
    logic [W-1:0]  alu_result;
    logic          alu_error;
    logic [W-1:0]  display;
    logic          display_error;

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_on = 0;

    always #5 clk = ~clk;

    calc_key_sequencer #(.WIDTH(W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_key_data      (key_data),
        .i_key_valid     (key_valid),
        .o_key_ready     (key_ready),
        .o_alu_a         (alu_a),
        .o_alu_b         (alu_b),
        .o_alu_op        (alu_op),
        .o_alu_valid     (alu_valid),
        .i_alu_ready     (alu_ready),
        .i_alu_done      (alu_done),
        .i_alu_result    (alu_result),
        .i_alu_error     (alu_error),
        .o_display       (display),
        .o_display_error (display_error)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Model: values held as signed integers, wrapped to W bits.
    // ------------------------------------------------------------------------
    typedef struct packed {
        int     mode;
        longint a;
        longint b;
        int     mag;
        bit     neg;
        int     op;
        int     nxt;   // -1: no chained operator
    } model_t;

    model_t mdl;

    function automatic longint wrap(input longint v);
        longint m;
        m = v & ((64'sd1 <<< W) - 64'sd1);
        if (m >= (64'sd1 <<< (W-1))) m = m - (64'sd1 <<< W);
        return m;
    endfunction

    function automatic logic [W-1:0] lo(input longint v);
        return v[W-1:0];
    endfunction

    function automatic model_t model_reset();
        model_t n;
        n = '0;
        n.mode = M_EA;
        n.nxt  = -1;
        return n;
    endfunction

    function automatic bit ready_of(input model_t m);
        return !(m.mode == M_REQ || m.mode == M_BUSY);
    endfunction

    function automatic longint entry_of(input model_t m);
        return wrap(m.neg ? -longint'(m.mag) : longint'(m.mag));
    endfunction

    function automatic longint disp_of(input model_t m);
        if (m.mode == M_EA || m.mode == M_EB) return entry_of(m);
        if (m.mode == M_ERR) return 0;
        return m.a;
    endfunction

    function automatic model_t step(input model_t m, input logic kv, input logic [4:0] k,
                                    input logic ar, input logic ad,
                                    input logic [W-1:0] res, input logic ae);
        model_t n;
        int     ki;
        longint ent;
        n   = m;
        ki  = int'(k);
        ent = entry_of(m);
        if (kv && ready_of(m)) begin
            if (ki == 21) begin
                n = model_reset();
            end else if (ki <= 22) begin
                case (m.mode)
                    M_EA, M_EB: begin
                        if (ki < 16) begin
                            if (m.mag < (1 << (W-5))) n.mag = m.mag * 16 + ki;
                        end else if (ki == 22) begin
                            n.neg = !m.neg;
                        end else if (m.mode == M_EA && ki < 20) begin
                            n.a = ent; n.op = ki - 16; n.mode = M_OP;
                        end else if (m.mode == M_EB && ki <= 20) begin
                            n.b = ent; n.nxt = (ki == 20) ? -1 : ki - 16; n.mode = M_REQ;
                        end
                    end
                    M_OP: begin
                        if (ki < 16) begin
                            n.mag = ki; n.neg = 0; n.mode = M_EB;
                        end else if (ki == 22) begin
                            n.mag = 0; n.neg = 1; n.mode = M_EB;
                        end else if (ki < 20) begin
                            n.op = ki - 16;
                        end
                    end
                    M_RES: begin
                        if (ki < 16) begin
                            n.mag = ki; n.neg = 0; n.mode = M_EA;
                        end else if (ki == 22) begin
                            n.a = wrap(-m.a);
                        end else if (ki < 20) begin
                            n.op = ki - 16; n.mode = M_OP;
                        end
                    end
                    default: ;
                endcase
            end
        end else if (m.mode == M_REQ && ar) begin
            n.mode = M_BUSY;
        end else if (m.mode == M_BUSY && ad) begin
            if (ae) begin
                n.mode = M_ERR;
            end else begin
                n.a = wrap(longint'(res));
                if (m.nxt >= 0) begin
                    n.op = m.nxt; n.nxt = -1; n.mode = M_OP;
                end else begin
                    n.mode = M_RES;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mdl <= model_reset();
        else        mdl <= step(mdl, key_valid, key_data, alu_ready, alu_done, alu_result, alu_error);
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("key_ready", key_ready, ready_of(mdl));
            chk("alu_valid", alu_valid, mdl.mode == M_REQ);
            chk("display", display, lo(disp_of(mdl)));
            chk("display_error", display_error, mdl.mode == M_ERR);
            if (mdl.mode == M_REQ) begin
                chk("req_a", alu_a, lo(mdl.a));
                chk("req_b", alu_b, lo(mdl.b));
                chk("req_op", alu_op, mdl.op[1:0]);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Drivers
    // ------------------------------------------------------------------------
    task automatic send_key(input logic [4:0] k);
        int n;
        bit took;
        key_data  = k;
        key_valid = 1'b1;
        took      = 0;
        n         = 0;
        while (!took && n < 40) begin
            @(negedge clk);
            if (key_ready) took = 1;
            n++;
        end
        @(posedge clk); #1;
        key_valid = 1'b0;
        chk("key_taken", took, 1);
    endtask

    // Serves one request. With stall > 0 the caller has already lowered
    // alu_ready and holds a key valid; both are released here.
    task automatic alu_serve(input logic [W-1:0] ea, input logic [W-1:0] eb,
                             input logic [1:0] eop, input int stall,
                             input logic [W-1:0] res, input logic err);
        int n;
        n = 0;
        while (!alu_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("lit_req_valid", alu_valid, 1);
        chk("lit_req_a", alu_a, ea);
        chk("lit_req_b", alu_b, eb);
        chk("lit_req_op", alu_op, eop);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_valid", alu_valid, 1);
            chk("stall_a", alu_a, ea);
            chk("stall_b", alu_b, eb);
            chk("stall_op", alu_op, eop);
            chk("stall_key_ready", key_ready, 0);
        end
        if (stall > 0) begin
            @(posedge clk); #1;
            alu_ready = 1'b1;
        end
        @(posedge clk); #1;
        if (stall > 0) begin
            chk("valid_drop", alu_valid, 0);
            key_valid = 1'b0;
        end
        @(posedge clk); #1;
        alu_done   = 1'b1;
        alu_result = res;
        alu_error  = err;
        @(posedge clk); #1;
        alu_done  = 1'b0;
        alu_error = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_key_ready"}, key_ready, 1);
        chk({tag, "_alu_valid"}, alu_valid, 0);
        chk({tag, "_alu_a"}, alu_a, 0);
        chk({tag, "_alu_b"}, alu_b, 0);
        chk({tag, "_alu_op"}, alu_op, 0);
        chk({tag, "_display"}, display, 0);
        chk({tag, "_display_error"}, display_error, 0);
    endtask

    initial begin
        int n;
        rst_n      = 1'b0;
        key_data   = '0;
        key_valid  = 1'b0;
        alu_ready  = 1'b1;
        alu_done   = 1'b0;
        alu_result = '0;
        alu_error  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        rst_n  = 1'b1;
        cmp_on = 1;

        // 0x12 + 3
        send_key(5'h01); send_key(5'h02);
        chk("t1_entry", display, 16'h0012);
        send_key(K_ADD); send_key(5'h03); send_key(K_EQ);
        alu_serve(16'h0012, 16'h0003, 2'b00, 0, 16'h0015, 1'b0);
        chk("t1_result", display, 16'h0015);

        // 5 * 3 - 2 chained; eq while an operator is pending is ignored
        send_key(5'h05); send_key(K_MUL); send_key(K_EQ);
        chk("t2_eq_ignored", display, 16'h0005);
        send_key(5'h03); send_key(K_SUB);
        alu_serve(16'h0005, 16'h0003, 2'b10, 0, 16'h000F, 1'b0);
        chk("t2_chain", display, 16'h000F);
        send_key(5'h02); send_key(K_EQ);
        alu_serve(16'h000F, 16'h0002, 2'b01, 0, 16'h000D, 1'b0);
        chk("t2_result", display, 16'h000D);

        // Digit overflow, sign toggling, reserved codes
        send_key(K_AC);
        send_key(5'h07); send_key(5'h0F); send_key(5'h0F); send_key(5'h0F);
        chk("t3_7fff", display, 16'h7FFF);
        send_key(5'h0F);
        chk("t3_dropped", display, 16'h7FFF);
        send_key(K_NEG);
        chk("t3_neg", display, 16'h8001);
        send_key(K_NEG);
        chk("t3_negneg", display, 16'h7FFF);
        send_key(5'h17); send_key(5'h1C); send_key(K_EQ);
        chk("t3_reserved", display, 16'h7FFF);

        // Divide by zero -> error, then AC
        send_key(K_AC);
        send_key(5'h08); send_key(K_DIV); send_key(5'h00); send_key(K_EQ);
        alu_serve(16'h0008, 16'h0000, 2'b11, 0, 16'h0000, 1'b1);
        chk("t4_err", display_error, 1);
        chk("t4_disp", display, 16'h0000);
        send_key(5'h01);
        chk("t4_err_hold", display_error, 1);
        chk("t4_disp_hold", display, 16'h0000);
        send_key(K_AC);
        chk("t4_ac_err", display_error, 0);
        chk("t4_ac_ready", key_ready, 1);

        // ALU stalls 5 cycles with a key waiting upstream
        send_key(5'h04); send_key(K_SUB); send_key(5'h01);
        alu_ready = 1'b0;
        send_key(K_EQ);
        key_data  = 5'h09;
        key_valid = 1'b1;
        alu_serve(16'h0004, 16'h0001, 2'b01, 5, 16'h0003, 1'b0);
        chk("t5_result", display, 16'h0003);

        // Operator replacement; most negative result survives neg
        send_key(K_AC);
        send_key(5'h01); send_key(K_SUB); send_key(K_ADD); send_key(5'h01); send_key(K_EQ);
        alu_serve(16'h0001, 16'h0001, 2'b00, 0, 16'h8000, 1'b0);
        chk("t6_min", display, 16'h8000);
        send_key(K_NEG);
        chk("t6_min_neg", display, 16'h8000);
        send_key(K_AC); send_key(K_NEG);
        chk("t6_neg_zero", display, 16'h0000);
        send_key(5'h03);
        chk("t6_neg_three", display, 16'hFFFD);

        // Reset while waiting on the ALU; the late result is ignored
        send_key(K_AC);
        send_key(5'h02); send_key(K_ADD); send_key(5'h02); send_key(K_EQ);
        n = 0;
        while (!alu_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t7_req_valid", alu_valid, 1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("t7_async");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        alu_done   = 1'b1;
        alu_result = 16'h1234;
        @(posedge clk); #1;
        alu_done = 1'b0;
        chk("t7_late_display", display, 16'h0000);
        chk("t7_late_ready", key_ready, 1);
        chk("t7_late_valid", alu_valid, 0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_key_sequencer.md
# calc_key_sequencer

Consumer end of the keypad key-code stream. Accepts 5-bit key codes over a valid/ready handshake, builds signed hex operands from digit keys, tracks the pending operator, and issues one arithmetic request per operation to the ALU over a second valid/ready handshake. ALU results chain into the next operation. The block sits between the keypad scanner and the ALU/display path, and drives the value shown on the display.

## Interface

Parameters:
- WIDTH, 16, operand/result width in bits; multiple of 4, ≥ 8.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_key_data  in  5  key code:
  - 0dddd: hex digit d.
  - 10000 add, 10001 sub, 10010 mul, 10011 div.
  - 10100 eq, 10101 AC, 10110 neg.
  - 10111 and 11xxx: reserved.
- i_key_valid  in  1  key code valid.
- o_key_ready  out  1  block can consume a key this cycle.
- o_alu_a  out  WIDTH  operand A, two's complement.
- o_alu_b  out  WIDTH  operand B, two's complement.
- o_alu_op  out  2  00 add, 01 sub, 10 mul, 11 div.
- o_alu_valid  out  1  request valid.
- i_alu_ready  in  1  ALU accepts request.
- i_alu_done  in  1  one-cycle result strobe.
- i_alu_result  in  WIDTH  result, valid with i_alu_done.
- i_alu_error  in  1  error flag (e.g. divide by zero), valid with i_alu_done.
- o_display  out  WIDTH  signed value to display.
- o_display_error  out  1  error indicator.

## Operation

- A key is consumed on a clk edge where i_key_valid && o_key_ready. Its effect takes hold at that edge.
- Reserved codes are consumed and ignored in every state.
- Entry register: magnitude mag[WIDTH-1:0] plus sign flag. Entry value = sign ? −mag : mag.
- Digit d is accepted only if mag < 2^(WIDTH−5); then mag ← (mag<<4)|d. Otherwise the digit is consumed and dropped.
- neg toggles the sign flag. −0 displays as 0.
- States:
  - ENTER_A:
    - Digit/neg edit the A entry.
    - add/sub/mul/div: A ← entry value, latch op → OP_PENDING.
    - eq ignored.
  - OP_PENDING:
    - Operator key replaces the latched op.
    - Digit d: B entry = {mag=d, sign=0} → ENTER_B.
    - neg: B entry = {mag=0, sign=1} → ENTER_B.
    - eq ignored.
  - ENTER_B:
    - Digit/neg edit the B entry.
    - Operator key: B ← entry value, pending_next ← that op → ISSUE.
    - eq: B ← entry value, pending_next ← none → ISSUE.
  - ISSUE: o_alu_valid=1, a/b/op held stable until i_alu_ready → WAIT.
  - WAIT:
    - i_alu_done && i_alu_error → ERROR.
    - i_alu_done && !i_alu_error: A ← i_alu_result. If pending_next is set: op ← pending_next → OP_PENDING. Otherwise → RESULT.
  - RESULT:
    - Digit d: A entry restarts at {mag=d, sign=0} → ENTER_A.
    - neg: A ← −A (two's complement wrap; −2^(WIDTH−1) stays unchanged).
    - Operator key: latch op → OP_PENDING.
    - eq ignored.
  - ERROR: o_display_error=1. All non-AC keys are consumed and ignored.
- AC, in any state where o_key_ready=1: clear A, B, entry, op, and pending_next → ENTER_A.
- o_key_ready = 1 in ENTER_A, OP_PENDING, ENTER_B, RESULT, ERROR; 0 in ISSUE and WAIT.
- o_display (combinational from state):
  - ENTER_A, ENTER_B: entry value.
  - ERROR: 0.
  - Otherwise: A.
- i_alu_done outside WAIT is ignored.

## Timing

- Reset values: state ENTER_A, o_key_ready=1, o_alu_valid=0, o_alu_a=0, o_alu_b=0, o_alu_op=00, o_display=0, o_display_error=0.
- o_alu_valid rises on the edge that consumes the terminating key, so the request is visible in the next cycle.
- Request handshake completes on the edge where o_alu_valid && i_alu_ready. If i_alu_ready is already high, ISSUE lasts exactly 1 cycle.
- o_key_ready rises the cycle after the i_alu_done edge.
- i_alu_done in the same cycle as request acceptance is not seen; it must come at least 1 cycle after the ready edge.
- Reset asserted mid-operation: all state clears asynchronously. o_alu_valid drops immediately.

## Test plan

- Keys 1,2,add,3,eq; ALU ready=1; done 2 cycles after accept with result 0x0015 → one request: a=0x0012, b=0x0003, op=00. Then state RESULT, o_display=0x0015.
- Keys 5,mul,3,sub; result 0x000F → request a=5, b=3, op=10. Block returns to OP_PENDING with op=01. Then keys 2,eq → request a=0x000F, b=0x0002, op=01.
- Keys 7,F,F,F,F → o_display=0x7FFF; the fifth digit is consumed and dropped. Then neg → 0x8001; neg → 0x7FFF.
- Keys 8,div,0,eq; done with i_alu_error=1 → o_display_error=1, o_display=0. Key 1 is consumed and ignored. AC → ENTER_A, error=0, display 0.
- Request issued with i_alu_ready low for 5 cycles → a/b/op/valid stable throughout, o_key_ready=0, the upstream key held valid is not consumed. Ready high → valid drops next cycle.
- rst_n pulsed low during WAIT → every output returns to its reset value immediately. A later i_alu_done is ignored.
